// File: rtl/ex_unit_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : ex_unit_pipe                                                  |
// | Description : Handshaked execute unit for the SCC datapath. Each accepted   |
// |               op is evaluated and held in one registered result slot until  |
// |               writeback takes it. Keeps a persistent N/C/Z/V flag register, |
// |               resolves conditional branches and shifts LSL/LSR either one   |
// |               bit per cycle (default) or in one cycle when the macro        |
// |               EX_BARREL_SHIFT_EN is defined.                                |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module ex_unit_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic              use_imm,
    input  logic              set_flags,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [IMM_W-1:0]  imm,
    input  logic [3:0]        cond,
    input  logic [DATA_W-1:0] pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              wr_en,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic [3:0]        flags
);

    localparam logic [3:0] c_op_mov   = 4'h0;
    localparam logic [3:0] c_op_add   = 4'h1;
    localparam logic [3:0] c_op_sub   = 4'h2;
    localparam logic [3:0] c_op_and   = 4'h3;
    localparam logic [3:0] c_op_or    = 4'h4;
    localparam logic [3:0] c_op_xor   = 4'h5;
    localparam logic [3:0] c_op_not   = 4'h6;
    localparam logic [3:0] c_op_movt  = 4'h7;
    localparam logic [3:0] c_op_lsl   = 4'h8;
    localparam logic [3:0] c_op_lsr   = 4'h9;
    localparam logic [3:0] c_op_clr   = 4'hA;
    localparam logic [3:0] c_op_set   = 4'hB;
    localparam logic [3:0] c_op_bcond = 4'hC;
    localparam logic [3:0] c_op_b     = 4'hD;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              wr_en_q, wr_en_d;
    logic              taken_q, taken_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [3:0]        flags_q, flags_d;   // {N, C, Z, V}

    logic [DATA_W-1:0] w_sext_imm;
    logic [DATA_W-1:0] w_op2;
    logic [SH_W-1:0]   w_amt;
    logic [DATA_W:0]   w_add;
    logic [DATA_W:0]   w_sub;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_v;
    logic              w_wr;
    logic              w_upd;
    logic              w_cond;
    logic              w_taken;
    logic [3:0]        w_flags_new;
    logic              w_accept;

    assign w_sext_imm = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign w_op2      = use_imm ? w_sext_imm : b;
    assign w_amt      = w_op2[SH_W-1:0];
    assign w_add      = {1'b0, a} + {1'b0, w_op2};
    assign w_sub      = {1'b0, a} - {1'b0, w_op2};

    // Reset gates in_ready so nothing is offered as accepted while rst is high.
    assign in_ready  = ~rst & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);

    assign result        = result_q;
    assign wr_en         = wr_en_q;
    assign branch_taken  = taken_q;
    assign branch_target = target_q;
    assign flags         = flags_q;

`ifdef EX_BARREL_SHIFT_EN
    // Extra bit beyond the data captures the last bit shifted out.
    logic [DATA_W:0] w_lsl;
    logic [DATA_W:0] w_lsr;
    assign w_lsl = {1'b0, a} << w_amt;
    assign w_lsr = {a, 1'b0} >> w_amt;
`else
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic              left_q, left_d;
    logic              setf_q, setf_d;
    logic              w_is_shift;
    logic [DATA_W-1:0] w_sh_next;
    logic              w_sh_out;
    assign w_is_shift = (op == c_op_lsl) | (op == c_op_lsr);
    assign w_sh_next  = left_q ? {result_q[DATA_W-2:0], 1'b0} : {1'b0, result_q[DATA_W-1:1]};
    assign w_sh_out   = left_q ? result_q[DATA_W-1] : result_q[0];
`endif

    // Single-cycle result and candidate flags for the offered op.
    always_comb begin
        w_res = '0;
        w_c   = flags_q[2];
        w_v   = flags_q[0];
        w_wr  = 1'b1;
        w_upd = 1'b0;
        case (op)
            c_op_mov:  w_res = w_sext_imm;
            c_op_add: begin
                w_res = w_add[DATA_W-1:0];
                w_c   = w_add[DATA_W];
                w_v   = (a[DATA_W-1] == w_op2[DATA_W-1]) & (w_res[DATA_W-1] != a[DATA_W-1]);
                w_upd = 1'b1;
            end
            c_op_sub: begin
                w_res = w_sub[DATA_W-1:0];
                w_c   = ~w_sub[DATA_W];
                w_v   = (a[DATA_W-1] != w_op2[DATA_W-1]) & (w_res[DATA_W-1] != a[DATA_W-1]);
                w_upd = 1'b1;
            end
            c_op_and: begin w_res = a & w_op2; w_upd = 1'b1; end
            c_op_or:  begin w_res = a | w_op2; w_upd = 1'b1; end
            c_op_xor: begin w_res = a ^ w_op2; w_upd = 1'b1; end
            c_op_not: begin w_res = ~a;        w_upd = 1'b1; end
            c_op_movt: w_res = {imm, a[DATA_W-IMM_W-1:0]};
`ifdef EX_BARREL_SHIFT_EN
            c_op_lsl: begin
                w_res = w_lsl[DATA_W-1:0];
                if (w_amt != '0) w_c = w_lsl[DATA_W];
                w_upd = 1'b1;
            end
            c_op_lsr: begin
                w_res = w_lsr[DATA_W:1];
                if (w_amt != '0) w_c = w_lsr[0];
                w_upd = 1'b1;
            end
`else
            // Only zero-amount shifts take this path; the value passes through.
            c_op_lsl, c_op_lsr: begin
                w_res = a;
                w_upd = 1'b1;
            end
`endif
            c_op_clr:  w_res = '0;
            c_op_set:  w_res = '1;
            default:   w_wr  = 1'b0;
        endcase
        w_flags_new = {w_res[DATA_W-1], w_c, ~|w_res, w_v};
    end

    // Branch condition against the committed flags.
    always_comb begin
        w_cond = 1'b0;
        case (cond)
            4'h0: w_cond = flags_q[1];
            4'h1: w_cond = ~flags_q[1];
            4'h2: w_cond = flags_q[2];
            4'h3: w_cond = ~flags_q[2];
            4'h4: w_cond = flags_q[3];
            4'h5: w_cond = ~flags_q[3];
            4'h6: w_cond = flags_q[0];
            4'h7: w_cond = ~flags_q[0];
            4'h8: w_cond = flags_q[2] & ~flags_q[1];
            4'h9: w_cond = ~flags_q[2] | flags_q[1];
            4'hA: w_cond = (flags_q[3] == flags_q[0]);
            4'hB: w_cond = (flags_q[3] != flags_q[0]);
            4'hC: w_cond = ~flags_q[1] & (flags_q[3] == flags_q[0]);
            4'hD: w_cond = flags_q[1] | (flags_q[3] != flags_q[0]);
            4'hE: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
        w_taken = ((op == c_op_bcond) & w_cond) | (op == c_op_b);
    end

    // Next-state logic: acceptance, iterative shifting and flag commit.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        wr_en_d  = wr_en_q;
        taken_d  = taken_q;
        target_d = target_q;
        flags_d  = flags_q;
`ifndef EX_BARREL_SHIFT_EN
        cnt_d  = cnt_q;
        left_d = left_q;
        setf_d = setf_q;
`endif
        if ((state_q == S_DONE) && out_ready) state_d = S_IDLE;
        if (w_accept) begin
            target_d = pc + w_sext_imm;
            taken_d  = w_taken;
            wr_en_d  = w_wr;
`ifndef EX_BARREL_SHIFT_EN
            if (w_is_shift && (w_amt != '0)) begin
                state_d  = S_SHIFT;
                result_d = a;
                cnt_d    = w_amt;
                left_d   = (op == c_op_lsl);
                setf_d   = set_flags;
            end else
`endif
            begin
                state_d  = S_DONE;
                result_d = w_res;
                if (set_flags && w_upd) flags_d = w_flags_new;
            end
        end
`ifndef EX_BARREL_SHIFT_EN
        if (state_q == S_SHIFT) begin
            result_d = w_sh_next;
            cnt_d    = cnt_q - SH_W'(1);
            if (cnt_q == SH_W'(1)) begin
                state_d = S_DONE;
                if (setf_q) flags_d = {w_sh_next[DATA_W-1], w_sh_out, ~|w_sh_next, flags_q[0]};
            end
        end
`endif
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            wr_en_q  <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            flags_q  <= '0;
`ifndef EX_BARREL_SHIFT_EN
            cnt_q    <= '0;
            left_q   <= 1'b0;
            setf_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            wr_en_q  <= wr_en_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            flags_q  <= flags_d;
`ifndef EX_BARREL_SHIFT_EN
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            setf_q   <= setf_d;
`endif
        end
    end

endmodule
`default_nettype wire
